booth_r4_multiplier: RTL and testbench

Parametrised sequential integer multiplier using radix-4 (modified Booth) recoding, retiring two multiplier bits per clock. It replaces the radix-2 shift-add multiplier in the arithmetic unit. It adds a run-time signed/unsigned mode, a synchronous reset, and a one-cycle done pulse. Latency is fixed and independent of mode and operand values.

---
 rtl/booth_r4_multiplier_if.sv | 19 +
 rtl/booth_r4_multiplier.sv | 107 ++++++++++
 tb/tb_booth_r4_multiplier.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/booth_r4_multiplier_if.sv
// Handshake and data bundle for booth_r4_multiplier.
//   start        request a multiply (taken only while ready=1)
//   signed_mode  1: operands are two's complement, 0: unsigned
//   A, B         multiplicand / multiplier, sampled with start
//   Product      2N-bit result register, held until the next op completes
//   ready        idle and able to accept start
//   done         one-cycle pulse, Product valid
interface booth_r4_multiplier_if #(parameter int N = 8);
  logic           start;
  logic           signed_mode;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic [2*N-1:0] Product;
  logic           ready;
  logic           done;

  modport master (output start, signed_mode, A, B, input Product, ready, done);
  modport slave  (input start, signed_mode, A, B, output Product, ready, done);
endinterface

// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 (modified Booth) multiplier, two multiplier bits per clock.
//   clk   rising-edge clock
//   rst   synchronous active-high reset; aborts any operation in flight
//   bus   booth_r4_multiplier_if.slave (start/signed_mode/A/B in,
//         Product/ready/done out)
// Operands are extended to N+2 bits (sign or zero by signed_mode) so one
// signed Booth recoding serves both modes. Latency is N/2+1 clocks from the
// accepting edge to done, independent of mode and data.
module booth_r4_multiplier #(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  booth_r4_multiplier_if.slave  bus
);
  localparam int ITER = N/2 + 1;
  localparam int W    = N + 2;       // extended operand width
  localparam int AW   = N + 4;       // accumulator / partial-sum width
  localparam int CW   = $clog2(ITER);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    m_q;              // extended multiplicand
  logic [W:0]      mplr_q;           // {extended multiplier, b[-1]}, shifts right by 2
  logic [AW-1:0]   acc_q;            // upper partial product
  logic [W-1:0]    lo_q;             // low product bits shifted out of acc
  logic [CW-1:0]   cnt_q;

  logic [AW-1:0]   m_ext, m2, pp, sum, acc_sh;
  logic [W-1:0]    lo_sh;
  logic [AW+W-1:0] full;
  logic            last;

  function automatic logic [W-1:0] ext(input logic [N-1:0] v, input logic s);
    return {{2{s & v[N-1]}}, v};
  endfunction

  // Booth digit select and one add/shift step
  always_comb begin
    m_ext = {{2{m_q[W-1]}}, m_q};
    m2    = {m_ext[AW-2:0], 1'b0};
    pp    = '0;
    unique case (mplr_q[2:0])
      3'b001, 3'b010: pp = m_ext;
      3'b011:         pp = m2;
      3'b100:         pp = AW'(0) - m2;
      3'b101, 3'b110: pp = AW'(0) - m_ext;
      default:        pp = '0;
    endcase
    sum    = acc_q + pp;
    // arithmetic >>2: the two low bits of the sum are final product bits
    acc_sh = {sum[AW-1], sum[AW-1], sum[AW-1:2]};
    lo_sh  = {sum[1:0], lo_q[W-1:2]};
    full   = {acc_sh, lo_sh};
    last   = (cnt_q == CW'(ITER-1));
  end

  assign bus.ready = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = BUSY;
      BUSY:    if (last)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.Product <= '0;
      bus.done    <= 1'b0;
      m_q         <= '0;
      mplr_q      <= '0;
      acc_q       <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
    end else begin
      bus.done <= 1'b0;
      if (state_q == IDLE) begin
        if (bus.start) begin
          m_q    <= ext(bus.A, bus.signed_mode);
          mplr_q <= {ext(bus.B, bus.signed_mode), 1'b0};
          acc_q  <= '0;
          lo_q   <= '0;
          cnt_q  <= '0;
        end
      end else begin
        acc_q  <= acc_sh;
        lo_q   <= lo_sh;
        mplr_q <= mplr_q >> 2;
        cnt_q  <= cnt_q + CW'(1);
        if (last) begin
          // all N+2 multiplier bits consumed; {acc,lo} is the exact product
          bus.Product <= full[2*N-1:0];
          bus.done    <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_booth_r4_multiplier.sv
module tb_booth_r4_multiplier;
  logic clk, rst;
  int   n_cmp = 0, n_err = 0;

  booth_r4_multiplier_if #(.N(8))  b8();
  booth_r4_multiplier_if #(.N(16)) b16();

  booth_r4_multiplier #(.N(8))  u8  (.clk(clk), .rst(rst), .bus(b8));
  booth_r4_multiplier #(.N(16)) u16 (.clk(clk), .rst(rst), .bus(b16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // plain integer arithmetic: interpret operands per mode, multiply, keep 2n bits
  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                          input bit sm, input int n);
    longint pa, pb, p;
    logic [63:0] mask;
    pa = longint'(a);
    pb = longint'(b);
    if (sm && a[n-1]) pa = pa - (longint'(1) << n);
    if (sm && b[n-1]) pb = pb - (longint'(1) << n);
    p    = pa * pb;
    mask = (64'd1 << (2*n)) - 64'd1;
    return 64'(p) & mask;
  endfunction

  // Issue one N=8 op and follow it to done (returns in the done cycle).
  // glitch: re-pulse start with different operands 2 cycles in.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit sm,
                     input logic [15:0] exp, input bit glitch, input string tag);
    logic [15:0] prev;
    bit early, moved;
    prev  = b8.Product;
    early = 0;
    moved = 0;
    b8.start = 1'b1; b8.A = a; b8.B = b; b8.signed_mode = sm;
    @(posedge clk); #1;
    b8.start = 1'b0;
    chk({tag, "_busy"}, 64'(b8.ready), 64'd0);
    chk({tag, "_done_low"}, 64'(b8.done), 64'd0);
    for (int j = 1; j < 5; j++) begin
      b8.A = 8'($urandom); b8.B = 8'($urandom); b8.signed_mode = 1'($urandom);
      if (glitch && j == 2) b8.start = 1'b1;
      if (glitch && j == 3) b8.start = 1'b0;
      @(posedge clk); #1;
      if (b8.done || b8.ready) early = 1;
      if (b8.Product !== prev) moved = 1;
    end
    b8.start = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_early"}, 64'(early), 64'd0);
    chk({tag, "_hold"}, 64'(moved), 64'd0);
    chk({tag, "_done"}, 64'(b8.done), 64'd1);
    chk({tag, "_ready"}, 64'(b8.ready), 64'd1);
    chk({tag, "_prod"}, 64'(b8.Product), 64'(exp));
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input bit sm);
    bit early;
    int lat;
    early = 0;
    lat   = 0;
    b16.start = 1'b1; b16.A = a; b16.B = b; b16.signed_mode = sm;
    @(posedge clk); #1;
    b16.start = 1'b0;
    for (int j = 1; j <= 12 && lat == 0; j++) begin
      b16.A = 16'($urandom); b16.B = 16'($urandom); b16.signed_mode = 1'($urandom);
      @(posedge clk); #1;
      if (b16.done) lat = j;
    end
    if (lat == 0) early = 1;
    chk("n16_timeout", 64'(early), 64'd0);
    chk("n16_latency", 64'(lat), 64'd9);
    chk("n16_prod", 64'(b16.Product), ref_mul(64'(a), 64'(b), sm, 16));
    @(posedge clk); #1;
    chk("n16_pulse", 64'(b16.done), 64'd0);
  endtask

  initial begin
    logic [15:0] corners [3];
    bit seen;
    corners[0] = 16'h8000; corners[1] = 16'hFFFF; corners[2] = 16'h0001;
    rst = 1'b1;
    b8.start = 0;  b8.A = 0;  b8.B = 0;  b8.signed_mode = 0;
    b16.start = 0; b16.A = 0; b16.B = 0; b16.signed_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_prod", 64'(b8.Product), 64'd0);
    chk("rst_ready", 64'(b8.ready), 64'd1);
    chk("rst_done", 64'(b8.done), 64'd0);
    chk("rst_ready16", 64'(b16.ready), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // most-negative squared, then one idle cycle: done must have dropped
    op8(8'h80, 8'h80, 1'b1, 16'h4000, 1'b0, "t1");
    @(posedge clk); #1;
    chk("t1_pulse", 64'(b8.done), 64'd0);
    chk("t1_keep", 64'(b8.Product), 64'h4000);

    op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0, "t2u");
    op8(8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b0, "t2s");
    @(posedge clk); #1;

    // back-to-back: second start lands in the done cycle of the first
    op8(8'hFF, 8'h7F, 1'b1, 16'hFF81, 1'b0, "t3a");
    op8(8'h00, 8'h5A, 1'b1, 16'h0000, 1'b0, "t3b");
    @(posedge clk); #1;

    // start while busy is ignored
    op8(8'h12, 8'h34, 1'b0, 16'h03A8, 1'b1, "t4");
    @(posedge clk); #1;
    chk("t4_pulse", 64'(b8.done), 64'd0);
    chk("t4_idle", 64'(b8.ready), 64'd1);

    // reset 3 cycles into an op
    b8.start = 1'b1; b8.A = 8'h7F; b8.B = 8'h7F; b8.signed_mode = 1'b1;
    @(posedge clk); #1;
    b8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_prod", 64'(b8.Product), 64'd0);
    chk("t5_ready", 64'(b8.ready), 64'd1);
    chk("t5_done", 64'(b8.done), 64'd0);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (b8.done) seen = 1;
    end
    chk("t5_no_done", 64'(seen), 64'd0);
    // rst with start: not accepted
    rst = 1'b1; b8.start = 1'b1; b8.A = 8'h11; b8.B = 8'h22;
    @(posedge clk); #1;
    rst = 1'b0; b8.start = 1'b0;
    chk("t5_rst_start", 64'(b8.ready), 64'd1);
    seen = 0;
    repeat (7) begin
      @(posedge clk); #1;
      if (b8.done || !b8.ready) seen = 1;
    end
    chk("t5_rst_start_idle", 64'(seen), 64'd0);

    // N=16: every corner pair in both modes, then random
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 3; i++)
        for (int k = 0; k < 3; k++)
          op16(corners[i], corners[k], 1'(m));
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 7) == 0) a = corners[$urandom_range(0, 2)];
      if ($urandom_range(0, 7) == 0) b = corners[$urandom_range(0, 2)];
      op16(a, b, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
